// File: rtl/float_to_fixed_pkg.sv
// rtl/float_to_fixed_pkg.sv - shared arithmetic constants for float to fixed conversion
//
// Purpose: IEEE-754 single field widths, bias, saturation limits of the
//          32-bit signed fixed-point result, and the operand class encoding.
// Ports:   none (package).
package float_to_fixed_pkg;

  localparam int          EXP_W    = 8;
  localparam int          MAN_W    = 23;
  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] FIX_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] FIX_MIN  = 32'h8000_0000;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,  // exponent 0: zero or denormal
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fclass_e;

endpackage

// File: rtl/shift_sticky.sv
// rtl/shift_sticky.sv - significand shifter with sticky and overflow detection
//
// Purpose: shifts a 24-bit significand left (sh_i >= 0) or right (sh_i < 0)
//          into a 32-bit magnitude.
// Ports:   sig_i    - 24-bit significand {1, mantissa}
//          sh_i     - signed shift amount, positive = left
//          mag_o    - 32-bit shifted magnitude
//          sticky_o - OR of all bits shifted out on the right
//          ovf_o    - a 1 would land above bit 31 on a left shift
module shift_sticky (
  input  logic [23:0]       sig_i,
  input  logic signed [9:0] sh_i,
  output logic [31:0]       mag_o,
  output logic              sticky_o,
  output logic              ovf_o
);

  logic [55:0] wide;
  logic [9:0]  rsh;

  always_comb begin
    mag_o    = '0;
    sticky_o = 1'b0;
    ovf_o    = 1'b0;
    wide     = '0;
    rsh      = -sh_i;
    if (!sh_i[9]) begin
      // Beyond 32 the whole significand is gone; decide by range, not by a
      // truncated shift count that could wrap around.
      if (sh_i > 10'sd32) begin
        ovf_o = |sig_i;
      end else begin
        wide  = {32'd0, sig_i} << sh_i[5:0];
        mag_o = wide[31:0];
        ovf_o = |wide[55:32];
      end
    end else begin
      if (rsh >= 10'd32) begin
        sticky_o = |sig_i;
      end else begin
        // Lower 32 bits of the window catch everything shifted out.
        wide     = {sig_i, 32'd0} >> rsh[4:0];
        mag_o    = {8'd0, wide[55:32]};
        sticky_o = |wide[31:0];
      end
    end
  end

endmodule

// File: rtl/float_to_fixed.sv
// rtl/float_to_fixed.sv - 3-stage IEEE-754 single to signed Q-format converter
//
// Purpose: converts a float to a 32-bit two's-complement value with FRAC_BITS
//          fraction bits, truncating toward zero and saturating out of range.
// Ports:   i_CLK, i_RST            - clock, synchronous active-high reset
//          i_VALID/o_READY/i_FLOAT - operand handshake and value
//          o_VALID/i_READY/o_FIXED - result handshake and value
//          o_OVERFLOW, o_INVALID, o_INEXACT - result flags
module float_to_fixed
  import float_to_fixed_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_VALID,
  output logic        o_READY,
  input  logic [31:0] i_FLOAT,
  output logic        o_VALID,
  input  logic        i_READY,
  output logic [31:0] o_FIXED,
  output logic        o_OVERFLOW,
  output logic        o_INVALID,
  output logic        o_INEXACT
);

  logic en;
  assign en      = ~o_VALID | i_READY;
  assign o_READY = en;

  // S1: unpack and classify
  logic [EXP_W-1:0] exp_w;
  logic [MAN_W-1:0] man_w;
  fclass_e          cls_d;
  logic signed [9:0] sh_d;

  assign exp_w = i_FLOAT[30:23];
  assign man_w = i_FLOAT[22:0];
  // Modulo-2^10 arithmetic yields the correct two's-complement shift.
  assign sh_d  = {2'b00, exp_w} - 10'(EXP_BIAS + MAN_W) + 10'(FRAC_BITS);

  always_comb begin
    cls_d = CLS_NORM;
    if (exp_w == '0)      cls_d = CLS_ZERO;
    else if (&exp_w)      cls_d = (man_w != '0) ? CLS_NAN : CLS_INF;
  end

  logic              v1_q, sign1_q, man_nz1_q;
  fclass_e           cls1_q;
  logic [23:0]       sig1_q;
  logic signed [9:0] sh1_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      v1_q      <= 1'b0;
      sign1_q   <= 1'b0;
      man_nz1_q <= 1'b0;
      cls1_q    <= CLS_ZERO;
      sig1_q    <= '0;
      sh1_q     <= '0;
    end else if (en) begin
      v1_q <= i_VALID;
      if (i_VALID) begin
        sign1_q   <= i_FLOAT[31];
        man_nz1_q <= (man_w != '0);
        cls1_q    <= cls_d;
        sig1_q    <= {1'b1, man_w};
        sh1_q     <= sh_d;
      end
    end
  end

  // S2: shift
  logic [31:0] mag_w;
  logic        sticky_w, sovf_w;

  shift_sticky u_shift (
    .sig_i    (sig1_q),
    .sh_i     (sh1_q),
    .mag_o    (mag_w),
    .sticky_o (sticky_w),
    .ovf_o    (sovf_w)
  );

  logic        v2_q, sign2_q, man_nz2_q, sticky2_q, ovf2_q;
  fclass_e     cls2_q;
  logic [31:0] mag2_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      v2_q      <= 1'b0;
      sign2_q   <= 1'b0;
      man_nz2_q <= 1'b0;
      sticky2_q <= 1'b0;
      ovf2_q    <= 1'b0;
      cls2_q    <= CLS_ZERO;
      mag2_q    <= '0;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sign2_q   <= sign1_q;
        man_nz2_q <= man_nz1_q;
        sticky2_q <= sticky_w;
        ovf2_q    <= sovf_w;
        cls2_q    <= cls1_q;
        mag2_q    <= mag_w;
      end
    end
  end

  // S3: negate and saturate
  logic [31:0] fixed_d;
  logic        ovf_d, inv_d, inx_d;

  always_comb begin
    fixed_d = '0;
    ovf_d   = 1'b0;
    inv_d   = 1'b0;
    inx_d   = 1'b0;
    case (cls2_q)
      CLS_NAN:  inv_d = 1'b1;
      CLS_INF: begin
        fixed_d = sign2_q ? FIX_MIN : FIX_MAX;
        ovf_d   = 1'b1;
      end
      CLS_ZERO: inx_d = man_nz2_q;
      CLS_NORM: begin
        // Negative side reaches one further: -2^31 is representable.
        if (ovf2_q || (!sign2_q && mag2_q[31]) || (sign2_q && mag2_q > FIX_MIN)) begin
          fixed_d = sign2_q ? FIX_MIN : FIX_MAX;
          ovf_d   = 1'b1;
        end else begin
          fixed_d = sign2_q ? (~mag2_q + 32'd1) : mag2_q;
          inx_d   = sticky2_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_VALID    <= 1'b0;
      o_FIXED    <= '0;
      o_OVERFLOW <= 1'b0;
      o_INVALID  <= 1'b0;
      o_INEXACT  <= 1'b0;
    end else if (en) begin
      o_VALID <= v2_q;
      if (v2_q) begin
        o_FIXED    <= fixed_d;
        o_OVERFLOW <= ovf_d;
        o_INVALID  <= inv_d;
        o_INEXACT  <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_float_to_fixed.sv
// tb/tb_float_to_fixed.sv - self-checking bench for float_to_fixed
module tb_float_to_fixed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_iv, a_or, a_ov, a_ir, a_ovf, a_inv, a_inx;
  logic [31:0] a_f, a_fx;
  logic        b_iv, b_or, b_ov, b_ir, b_ovf, b_inv, b_inx;
  logic [31:0] b_f, b_fx;

  float_to_fixed #(.FRAC_BITS(0)) dut_a (
    .i_CLK(clk), .i_RST(rst), .i_VALID(a_iv), .o_READY(a_or), .i_FLOAT(a_f),
    .o_VALID(a_ov), .i_READY(a_ir), .o_FIXED(a_fx), .o_OVERFLOW(a_ovf),
    .o_INVALID(a_inv), .o_INEXACT(a_inx)
  );

  float_to_fixed #(.FRAC_BITS(16)) dut_b (
    .i_CLK(clk), .i_RST(rst), .i_VALID(b_iv), .o_READY(b_or), .i_FLOAT(b_f),
    .o_VALID(b_ov), .i_READY(b_ir), .o_FIXED(b_fx), .o_OVERFLOW(b_ovf),
    .o_INVALID(b_inv), .o_INEXACT(b_inx)
  );

  // fl = {overflow, invalid, inexact}
  typedef struct {
    logic [31:0] fx;
    logic [2:0]  fl;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t pa, pb;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   a_acc, b_acc;
  bit   bp_on = 1'b0;
  int   bp_idx = 0;
  logic [5:0] bp_pat = 6'b110100;  // bit i = i_READY in stall step i

  function automatic exp_t mk(logic [31:0] fx, logic ovf, logic inv, logic inx);
    exp_t r;
    r.fx = fx; r.fl = {ovf, inv, inx}; r.acc = 0; r.lat = 1'b0;
    return r;
  endfunction

  // Reference conversion using 64-bit magnitudes.
  function automatic exp_t model(logic [31:0] f, int fb);
    exp_t        r;
    logic [63:0] sig, m;
    int          e, n;
    bit          big, inx;
    r = mk(32'd0, 1'b0, 1'b0, 1'b0);
    big = 1'b0; inx = 1'b0; m = '0;
    sig = {40'd0, 1'b1, f[22:0]};
    if (f[30:23] == 8'hFF) begin
      if (f[22:0] != 0) r.fl = 3'b010;
      else begin
        r.fx = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.fl = 3'b100;
      end
      return r;
    end
    if (f[30:23] == 8'h00) begin
      r.fl = {2'b00, f[22:0] != 0};
      return r;
    end
    e = int'(f[30:23]) - 150 + fb;
    if (e > 40) big = 1'b1;
    else if (e >= 0) m = sig << e;
    else begin
      n = -e;
      if (n >= 63) inx = 1'b1;
      else begin
        m   = sig >> n;
        inx = ((sig & ((64'd1 << n) - 64'd1)) != 64'd0);
      end
    end
    if (big || (!f[31] && m > 64'h7FFF_FFFF) || (f[31] && m > 64'h8000_0000)) begin
      r.fx = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      r.fl = 3'b100;
    end else begin
      r.fx = f[31] ? (~m[31:0] + 32'd1) : m[31:0];
      r.fl = {2'b00, inx};
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    a_acc = a_iv && a_or;
    b_acc = b_iv && b_or;
    if (a_ov) begin
      if (qa.size() == 0) check("a_spurious", 32'(a_ov), 32'd0);
      else begin
        e = qa[0];
        check("a_fixed", a_fx, e.fx);
        check("a_flags", {29'd0, a_ovf, a_inv, a_inx}, {29'd0, e.fl});
        if (a_ir) begin
          if (e.lat) check("a_latency", 32'(cyc - e.acc), 32'd3);
          void'(qa.pop_front());
        end
      end
    end
    if (b_ov) begin
      if (qb.size() == 0) check("b_spurious", 32'(b_ov), 32'd0);
      else begin
        e = qb[0];
        check("b_fixed", b_fx, e.fx);
        check("b_flags", {29'd0, b_ovf, b_inv, b_inx}, {29'd0, e.fl});
        if (b_ir) void'(qb.pop_front());
      end
    end
    if (a_acc) begin pa.acc = cyc; qa.push_back(pa); end
    if (b_acc) begin pb.acc = cyc; qb.push_back(pb); end
    @(posedge clk);
    #1;
    if (bp_on) begin
      a_ir = bp_pat[bp_idx % 6];
      bp_idx++;
    end
  endtask

  task automatic send_a(logic [31:0] f, exp_t e);
    a_f = f; a_iv = 1'b1; pa = e;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (a_acc) break;
    end
    if (!a_acc) check("a_accept_timeout", 32'd0, 32'd1);
    a_iv = 1'b0;
  endtask

  task automatic send_b(logic [31:0] f, exp_t e);
    b_f = f; b_iv = 1'b1; pb = e;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (b_acc) break;
    end
    if (!b_acc) check("b_accept_timeout", 32'd0, 32'd1);
    b_iv = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      tick();
    end
    check("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] f;
    rst = 1'b1;
    a_iv = 1'b0; a_f = '0; a_ir = 1'b1;
    b_iv = 1'b0; b_f = '0; b_ir = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    a_ir = 1'b0;
    check("rst_o_valid", 32'(a_ov), 32'd0);
    check("rst_o_fixed", a_fx, 32'd0);
    check("rst_flags", {29'd0, a_ovf, a_inv, a_inx}, 32'd0);
    check("rst_o_ready", 32'(a_or), 32'd1);
    a_ir = 1'b1;

    // 1.0 with latency check
    e = mk(32'h0000_0001, 1'b0, 1'b0, 1'b0);
    e.lat = 1'b1;
    send_a(32'h3F80_0000, e);
    drain();

    // directed FRAC_BITS=0 values, back-to-back
    send_a(32'hC020_0000, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1));
    send_a(32'hCF00_0000, mk(32'h8000_0000, 1'b0, 1'b0, 1'b0));
    send_a(32'h4F00_0000, mk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0));
    send_a(32'h7FC0_0000, mk(32'h0000_0000, 1'b0, 1'b1, 1'b0));
    send_a(32'hFF80_0000, mk(32'h8000_0000, 1'b1, 1'b0, 1'b0));
    send_a(32'h7F80_0000, mk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0));
    send_a(32'h8000_0000, mk(32'h0000_0000, 1'b0, 1'b0, 1'b0));
    send_a(32'h0000_0001, mk(32'h0000_0000, 1'b0, 1'b0, 1'b1));
    send_a(32'hCF00_0001, mk(32'h8000_0000, 1'b1, 1'b0, 1'b0));
    send_a(32'h3E80_0000, mk(32'h0000_0000, 1'b0, 1'b0, 1'b1));
    drain();

    // FRAC_BITS=16
    send_b(32'h3FC0_0000, mk(32'h0001_8000, 1'b0, 1'b0, 1'b0));
    send_b(32'h3380_0000, mk(32'h0000_0000, 1'b0, 1'b0, 1'b1));
    send_b(32'h4700_0000, mk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0));
    send_b(32'hC700_0000, mk(32'h8000_0000, 1'b0, 1'b0, 1'b0));
    drain();

    // randomized operands against the reference model
    for (int i = 0; i < 10; i++) begin
      f = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 170)), 23'($urandom)};
      send_a(f, model(f, 0));
      f = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      send_b(f, model(f, 16));
    end
    drain();

    // back-pressure: i_READY follows 0,0,1,0,1,1 repeating
    bp_on = 1'b1; bp_idx = 0;
    a_ir = bp_pat[0]; bp_idx = 1;
    for (int i = 0; i < 6; i++) begin
      f = {1'(i[0]), 8'(127 + i * 3), 23'($urandom)};
      send_a(f, model(f, 0));
    end
    drain();
    bp_on = 1'b0;
    a_ir = 1'b1;

    // reset with three operands in flight
    send_a(32'h4040_0000, mk(32'h0000_0003, 1'b0, 1'b0, 1'b0));
    send_a(32'h4080_0000, mk(32'h0000_0004, 1'b0, 1'b0, 1'b0));
    send_a(32'h40A0_0000, mk(32'h0000_0005, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    qa.delete();
    qb.delete();
    check("midrst_o_valid", 32'(a_ov), 32'd0);
    check("midrst_o_ready", 32'(a_or), 32'd1);
    send_a(32'h4110_0000, mk(32'h0000_0009, 1'b0, 1'b0, 1'b0));
    drain();
    for (int k = 0; k < 5; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_to_fixed.md
FLOAT_TO_FIXED -- requirements
Module: float_to_fixed

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 0: number of fraction bits in the output Q format; legal range 0..31.
REQ-002 SHALL have port i_CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_VALID  input  1  upstream asserts that i_FLOAT holds a valid operand.
REQ-005 SHALL have port o_READY  output  1  block accepts i_FLOAT this cycle when i_VALID is also high.
REQ-006 SHALL have port i_FLOAT  input  32  IEEE-754 single: sign [31], exponent [30:23], mantissa [22:0].
REQ-007 SHALL have port o_VALID  output  1  o_FIXED and the flags hold a valid result.
REQ-008 SHALL have port i_READY  input  1  downstream accepts the result this cycle when o_VALID is also high.
REQ-009 SHALL have port o_FIXED  output  32  two's-complement signed fixed-point value with FRAC_BITS fraction bits.
REQ-010 SHALL have port o_OVERFLOW  output  1  the result saturated (magnitude out of range, or infinity).
REQ-011 SHALL have port o_INVALID  output  1  the input was NaN.
REQ-012 SHALL have port o_INEXACT  output  1  nonzero bits were discarded by truncation.

Function
REQ-013 SHALL be a 3-stage pipeline:
- S1: unpack, classify, and compute shift amount sh = exp - 127 + FRAC_BITS - 23 as a signed 10-bit value.
- S2: shift the 24-bit significand {1,mantissa} left by sh (sh >= 0) or right by -sh (sh < 0), collecting sticky bits.
- S3: negate, saturate, and register the outputs.
REQ-014 SHALL produce a result with latency exactly 3 cycles from acceptance to o_VALID when i_READY is held high.
REQ-015 SHALL advance all stages together on enable en = ~o_VALID | i_READY, with o_READY = en.
REQ-016 SHALL capture an input only when i_VALID & o_READY.
REQ-017 SHALL advance bubbles as invalid stages while en is high.
REQ-018 SHALL hold all stage registers unchanged while en is low; no result is lost or duplicated.
REQ-019 SHALL sustain a throughput of one result per cycle when i_VALID and i_READY are continuously high.
REQ-020 SHALL round by truncation toward zero; o_INEXACT=1 when any right-shifted-out bit is 1.
REQ-021 SHALL treat exponent 0 (zero or denormal) as result 0, with o_INEXACT=1 if the mantissa is nonzero.
REQ-022 SHALL, for NaN (exponent 255, mantissa nonzero), output 0 with o_INVALID=1 and o_OVERFLOW=0.
REQ-023 SHALL saturate infinity to 0x7FFFFFFF (+) or 0x80000000 (-), with o_OVERFLOW=1.
REQ-024 SHALL saturate any magnitude > 2^31-1 to 0x7FFFFFFF (positive) or any magnitude > 2^31 to 0x80000000 (negative), with o_OVERFLOW=1.
REQ-025 SHALL output a negative magnitude of exactly 2^31 as 0x80000000 with o_OVERFLOW=0.
REQ-026 SHALL force a right shift of 32 or more to magnitude 0, with sticky equal to the OR of all significand bits.
REQ-027 SHALL treat any left shift that would move a 1 beyond bit 31 as overflow, without relying on wrapped shift counts.
REQ-028 SHALL output -0.0 (0x80000000) as 0x00000000 with no flags set.
REQ-029 SHALL hold o_FIXED and the flags stable while o_VALID & ~i_READY.

Reset
REQ-030 SHALL, on i_RST high at a clock edge, clear all stage valid bits; o_VALID=0, o_FIXED=0, o_OVERFLOW=0, o_INVALID=0, o_INEXACT=0.
REQ-031 SHALL discard in-flight operands when reset is asserted mid-operation; no stale result appears after reset.
REQ-032 SHALL drive o_READY=1 in the first cycle after reset deasserts.

Structure
REQ-033 SHALL take the following from the shared arithmetic constants package: EXP_W=8, MAN_W=23, EXP_BIAS=127, FIX_MAX=0x7FFFFFFF, FIX_MIN=0x80000000.
REQ-034 SHALL place the S2 shifter in one sub-module, shift_sticky, taking a 24-bit significand and a signed shift and returning a 32-bit magnitude, a sticky bit, and an overflow bit.
REQ-035 SHALL keep all other logic in float_to_fixed; no additional sub-modules.

Verification
REQ-036 SHALL cover, with FRAC_BITS=0 and i_READY=1: input 0x3F800000 (1.0) -> 0x00000001 exactly 3 cycles later, no flags set.
REQ-037 SHALL cover, with FRAC_BITS=0: 0xC0200000 (-2.5) -> 0xFFFFFFFE with o_INEXACT=1; 0xCF000000 (-2^31) -> 0x80000000 with o_OVERFLOW=0; 0x4F000000 (2^31) -> 0x7FFFFFFF with o_OVERFLOW=1.
REQ-038 SHALL cover: 0x7FC00000 (NaN) -> 0x00000000 with o_INVALID=1; 0xFF800000 (-inf) -> 0x80000000 with o_OVERFLOW=1.
REQ-039 SHALL cover, with FRAC_BITS=16: 0x3FC00000 (1.5) -> 0x00018000; 0x33800000 (2^-24) -> 0x00000000 with o_INEXACT=1.
REQ-040 SHALL cover back-pressure: 6 back-to-back valid inputs with i_READY toggled 0,0,1,0,1,1... -> results in order, none lost or duplicated, and o_FIXED stable while stalled.
REQ-041 SHALL cover reset mid-operation: assert i_RST for 1 cycle with 3 operands in flight -> o_VALID=0 the next cycle, and the first result after reset belongs to the first post-reset input.
